// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared constants and types for the ground-map writer path.
//   MAP_MAX        largest valid ground-plane coordinate (inclusive)
//   ROW_STRIDE     framebuffer words per row (coordinates 0..MAP_MAX)
//   GM_ADDR_W      ground-map RAM address width
//   GM_DATA_W      ground-map RAM data width (stored point index)
//   ground_point_t one buffered write: {addr, p}
// -----------------------------------------------------------------------------
package maze_pkg;

    localparam int MAP_MAX    = 320;
    localparam int ROW_STRIDE = MAP_MAX + 1;
    localparam int GM_ADDR_W  = 17;
    localparam int GM_DATA_W  = 10;

    typedef struct packed {
        logic [GM_ADDR_W-1:0] addr;
        logic [GM_DATA_W-1:0] p;
    } ground_point_t;

endpackage

// File: rtl/ground_point_fifo.sv
// -----------------------------------------------------------------------------
// ground_point_fifo
// Synchronous FIFO with push/pop/flush. The head entry is visible on dout
// combinationally; pop advances to the next entry on the clock edge.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   store din at the tail
//   pop         discard the head (caller guarantees the FIFO is not empty)
//   flush       drop all contents; a push in the same cycle becomes entry 0
//   dout        head entry
//   count       occupancy, 0..DEPTH
//   full, empty occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ground_point_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 27
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push that coincides with a flush lands in slot 0 of the emptied queue.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[flush ? '0 : wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= PTR_W'(push);
            count  <= CNT_W'(push);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ground_point_writer.sv
// -----------------------------------------------------------------------------
// ground_point_writer
// Buffers projected ground points and writes them to the ground-map RAM via a
// we/ack handshake so RAM back-pressure never stalls the projection pipeline.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_x, in_y, in_p    point coordinates (bits 8:0 used) and stored index
//   in_en               point valid this cycle
//   frame_start         new frame: flush queue, clear overflow
//   mem_addr, mem_data  write address/data, held while mem_we and no ack
//   mem_we              write request
//   mem_ack             RAM accepted the write on this edge
//   fifo_count          queued entries (not counting the write in flight)
//   overflow            sticky: a point was dropped this frame
//   busy                queue non-empty or write in flight
// Optional build macro: GROUND_DEDUP_EN -- drop a point whose address equals
// that of the previously accepted point in the current frame.
// ADDR_W/DATA_W must match the widths of maze_pkg::ground_point_t.
// -----------------------------------------------------------------------------
module ground_point_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ROW_STRIDE = maze_pkg::ROW_STRIDE,
    parameter int ADDR_W     = maze_pkg::GM_ADDR_W,
    parameter int DATA_W     = maze_pkg::GM_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [9:0]             in_x,
    input  logic signed [9:0]             in_y,
    input  logic signed [9:0]             in_p,
    input  logic                          in_en,
    input  logic                          frame_start,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data,
    output logic                          mem_we,
    input  logic                          mem_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);

    import maze_pkg::*;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] push_addr;
    ground_point_t     push_point;
    ground_point_t     head_point;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_avail;
    logic              pop;
    logic              push;
    logic              dup;
    logic              drop;
    logic              unused_sign;

    // Valid points are non-negative, so the sign bits carry no information.
    assign unused_sign = in_x[9] ^ in_y[9];

    assign push_addr = ADDR_W'(in_y[8:0]) * ADDR_W'(ROW_STRIDE) + ADDR_W'(in_x[8:0]);
    assign push_point.addr = push_addr;
    assign push_point.p    = in_p;

    // During frame_start the queued entries are being discarded, so nothing
    // may be popped from them in that cycle.
    assign head_avail = !fifo_empty && !frame_start;
    assign pop        = head_avail && ((state == IDLE) || mem_ack);

`ifdef GROUND_DEDUP_EN
    logic              last_valid;
    logic [ADDR_W-1:0] last_addr;

    // frame_start invalidates the remembered address before comparing, so the
    // first point of a new frame is never treated as a duplicate.
    assign dup = last_valid && !frame_start && (push_addr == last_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_addr  <= push_addr;
        end else if (frame_start) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // A full queue still accepts when the head leaves this cycle or the
    // queue is being flushed.
    assign push = in_en && !dup && (!fifo_full || pop || frame_start);
    assign drop = in_en && !dup && !push;

    ground_point_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ground_point_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (frame_start),
        .din   (push_point),
        .dout  (head_point),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (frame_start) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Popping from WRITE on an ack chains writes back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop) begin
            state    <= WRITE;
            mem_addr <= head_point.addr;
            mem_data <= head_point.p;
        end else if ((state == WRITE) && mem_ack) begin
            state    <= IDLE;
        end
    end

    assign mem_we = (state == WRITE);
    assign busy   = (fifo_count != '0) || (state == WRITE);

endmodule

// File: tb/tb_ground_point_writer.sv
// -----------------------------------------------------------------------------
// tb_ground_point_writer
// Self-checking bench for ground_point_writer. A queue-based model of the
// pending points and the write in flight is compared against the DUT on every
// cycle out of reset; completed writes are logged and pinned against
// hand-computed literals per directed scenario.
// Honours the GROUND_DEDUP_EN build macro.
// -----------------------------------------------------------------------------
module tb_ground_point_writer;

    import maze_pkg::*;

    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [9:0]  in_x = '0;
    logic signed [9:0]  in_y = '0;
    logic signed [9:0]  in_p = '0;
    logic               in_en = 1'b0;
    logic               frame_start = 1'b0;
    logic               mem_ack = 1'b0;
    logic [16:0]        mem_addr;
    logic [9:0]         mem_data;
    logic               mem_we;
    logic [4:0]         fifo_count;
    logic               overflow;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;

    ground_point_t mq[$];
    ground_point_t mi;
    bit            mi_valid = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_last_valid = 1'b0;
    logic [16:0]   m_last_addr = '0;
    ground_point_t wlog[$];
    ground_point_t exp_log[$];

    ground_point_writer #(
        .FIFO_DEPTH (DEPTH),
        .ROW_STRIDE (321),
        .ADDR_W     (17),
        .DATA_W     (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_p        (in_p),
        .in_en       (in_en),
        .frame_start (frame_start),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int got, input int expected);
        checks++;
        if (got != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, got, expected);
        end
    endtask

    task automatic apply_stimulus(input bit en, input int x, input int y, input int p,
                                  input bit fs, input bit ack);
        @(negedge clk);
        in_en       = en;
        in_x        = 10'(x);
        in_y        = 10'(y);
        in_p        = 10'(p);
        frame_start = fs;
        mem_ack     = ack;
    endtask

    task automatic expect_write(input int addr, input int p);
        ground_point_t e;
        e.addr = 17'(addr);
        e.p    = 10'(p);
        exp_log.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        apply_stimulus(0, 0, 0, 0, 0, 1);
        while (busy && n < 60) begin
            apply_stimulus(0, 0, 0, 0, 0, 1);
            n++;
        end
        if (busy) check_output({name, "_drain_timeout"}, int'(busy), 0);
    endtask

    task automatic check_log(input string name);
        check_output({name, "_write_count"}, wlog.size(), exp_log.size());
        for (int i = 0; i < wlog.size() && i < exp_log.size(); i++) begin
            check_output($sformatf("%s_addr[%0d]", name, i), int'(wlog[i].addr), int'(exp_log[i].addr));
            check_output($sformatf("%s_data[%0d]", name, i), int'(wlog[i].p), int'(exp_log[i].p));
        end
        wlog.delete();
        exp_log.delete();
    endtask

    // Model: pending points in arrival order plus the one write being offered.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mi_valid     = 1'b0;
            m_ovf        = 1'b0;
            m_last_valid = 1'b0;
        end else begin : model_step
            ground_point_t np;
            bit ack_done;
            bit issue;
            bit dup;
            bit accept;
            np.addr  = 17'(int'(in_y[8:0]) * 321 + int'(in_x[8:0]));
            np.p     = in_p;
            ack_done = mi_valid && mem_ack;
            issue    = (!mi_valid || ack_done) && (mq.size() > 0) && !frame_start;
            dup      = 1'b0;
`ifdef GROUND_DEDUP_EN
            dup = m_last_valid && !frame_start && (np.addr == m_last_addr);
`endif
            accept = in_en && !dup && (frame_start || mq.size() < DEPTH || issue);
            if (ack_done) wlog.push_back(mi);
            if (frame_start) begin
                mq.delete();
                m_ovf        = 1'b0;
                m_last_valid = 1'b0;
            end
            if (issue) mi = mq.pop_front();
            mi_valid = issue || (mi_valid && !ack_done);
            if (accept) begin
                mq.push_back(np);
                m_last_valid = 1'b1;
                m_last_addr  = np.addr;
            end else if (in_en && !dup) begin
                m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("mem_we", int'(mem_we), int'(mi_valid));
            if (mi_valid) begin
                check_output("mem_addr", int'(mem_addr), int'(mi.addr));
                check_output("mem_data", int'(mem_data), int'(mi.p));
            end
            check_output("fifo_count", int'(fifo_count), mq.size());
            check_output("overflow", int'(overflow), int'(m_ovf));
            check_output("busy", int'(busy), int'(mq.size() != 0 || mi_valid));
            if (mem_we) we_cycles++;
        end
    end

    initial begin
        // Reset values
        #12;
        check_output("reset_mem_we", int'(mem_we), 0);
        check_output("reset_mem_addr", int'(mem_addr), 0);
        check_output("reset_mem_data", int'(mem_data), 0);
        check_output("reset_fifo_count", int'(fifo_count), 0);
        check_output("reset_overflow", int'(overflow), 0);
        check_output("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 1);

        // Single point, ack tied high
        we_cycles = 0;
        apply_stimulus(1, 5, 2, 7, 0, 1);
        drain("single");
        check_output("single_we_cycles", we_cycles, 1);
        expect_write(647, 7);
        check_log("single");

        // Corner coordinates back to back
        apply_stimulus(1, 0, 0, 1, 0, 1);
        apply_stimulus(1, 320, 320, 2, 0, 1);
        drain("corner");
        check_output("corner_overflow", int'(overflow), 0);
        expect_write(0, 1);
        expect_write(103040, 2);
        check_log("corner");

        // Stall: address/data held while ack stays low
        we_cycles = 0;
        apply_stimulus(1, 7, 4, 11, 0, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("stall_addr_held", int'(mem_addr), 1291);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        drain("stall");
        check_output("stall_we_cycles", we_cycles, 6);
        expect_write(1291, 11);
        check_log("stall");

        // Back-pressure: one point in flight plus 16 queued, the 18th dropped
        for (int i = 0; i < 18; i++) apply_stimulus(1, i + 1, 3, i + 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("bp_fifo_count", int'(fifo_count), 16);
        check_output("bp_overflow", int'(overflow), 1);
        drain("bp");
        for (int i = 0; i < 17; i++) expect_write(964 + i, i + 1);
        check_log("bp");

        // Flush with a write in flight and a new point in the same cycle
        apply_stimulus(1, 2, 0, 21, 0, 0);
        apply_stimulus(1, 3, 0, 22, 0, 0);
        apply_stimulus(1, 4, 0, 23, 0, 0);
        apply_stimulus(1, 5, 0, 24, 0, 0);
        apply_stimulus(1, 1, 1, 5, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("flush_fifo_count", int'(fifo_count), 1);
        check_output("flush_overflow", int'(overflow), 0);
        drain("flush");
        expect_write(2, 21);
        expect_write(322, 5);
        check_log("flush");

        // Repeated address
        apply_stimulus(1, 10, 10, 3, 0, 1);
        apply_stimulus(1, 10, 10, 9, 0, 1);
        drain("dup");
        expect_write(3220, 3);
`ifndef GROUND_DEDUP_EN
        expect_write(3220, 9);
`endif
        check_log("dup");

        // Reset in the middle of a write
        apply_stimulus(1, 1, 0, 1, 0, 0);
        apply_stimulus(1, 2, 0, 2, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_mem_we", int'(mem_we), 0);
        check_output("rst_mid_fifo_count", int'(fifo_count), 0);
        check_output("rst_mid_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("rst_mid");
        check_log("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
